// File: rtl/mem_image_loader_if.sv
// Loader-side bundle: UART byte stream in, RAM write port and load status out.
// master = loader, slave = the environment (UART receiver, RAM mux, pipeline).
interface mem_image_loader_if;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] mem_addr;
    logic [63:0] mem_dina;
    logic [7:0]  mem_wea;
    logic        interlock;
    logic        done;
    logic        err;
    logic [31:0] word_count;

    modport master (
        input  start, rx_data, rx_valid,
        output rx_ready, mem_addr, mem_dina, mem_wea, interlock, done, err, word_count
    );

    modport slave (
        output start, rx_data, rx_valid,
        input  rx_ready, mem_addr, mem_dina, mem_wea, interlock, done, err, word_count
    );
endinterface

// File: rtl/mem_image_loader.sv
// Streams a big-endian header+image from UART bytes into 64-bit RAM writes; write lands 1 cycle after a word's 8th byte.
// Backpressure: rx_ready only in HDR/DATA, so bytes stall during WRITE/DONE/IDLE; interlock holds the pipeline meanwhile.
module mem_image_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter logic [31:0] MAX_WORDS = 32'h20000
) (
    input  logic              clk,
    input  logic              rstn,
    mem_image_loader_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_byte_cnt;
    logic [31:0] r_word_count;
    logic [31:0] r_word_idx;
    logic [63:0] r_shift;
    logic        r_err;

    logic        w_rx_ready;
    logic        w_take;
    logic [31:0] w_hdr_word;
    logic        w_last_hdr;
    logic        w_last_data;
    logic        w_last_word;

    assign w_rx_ready  = (r_state == S_HDR) || (r_state == S_DATA);
    assign w_take      = bus.rx_valid && w_rx_ready;
    assign w_hdr_word  = {r_word_count[23:0], bus.rx_data};
    assign w_last_hdr  = (r_byte_cnt == 3'd3);
    assign w_last_data = (r_byte_cnt == 3'd7);
    assign w_last_word = ((r_word_idx + 32'd1) == r_word_count);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_HDR;
            S_HDR: begin
                if (w_take && w_last_hdr) begin
                    // Empty and oversize images both finish without touching the RAM
                    if ((w_hdr_word == 32'd0) || (w_hdr_word > MAX_WORDS)) w_next = S_DONE;
                    else                                                   w_next = S_DATA;
                end
            end
            S_DATA:  if (w_take && w_last_data) w_next = S_WRITE;
            S_WRITE: w_next = w_last_word ? S_DONE : S_DATA;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.rx_ready   = w_rx_ready;
        bus.mem_wea    = (r_state == S_WRITE) ? 8'hFF : 8'h00;
        bus.mem_addr   = BASE_ADDR + r_word_idx;
        bus.mem_dina   = r_shift;
        bus.interlock  = (r_state != S_IDLE);
        bus.done       = (r_state == S_DONE);
        bus.err        = r_err;
        bus.word_count = r_word_count;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_byte_cnt   <= 3'd0;
            r_word_count <= 32'd0;
            r_word_idx   <= 32'd0;
            r_shift      <= 64'd0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_byte_cnt   <= 3'd0;
                        r_word_count <= 32'd0;
                        r_word_idx   <= 32'd0;
                        r_shift      <= 64'd0;
                        r_err        <= 1'b0;
                    end
                end
                S_HDR: begin
                    if (w_take) begin
                        r_word_count <= w_hdr_word;
                        r_byte_cnt   <= w_last_hdr ? 3'd0 : r_byte_cnt + 3'd1;
                        if (w_last_hdr && (w_hdr_word > MAX_WORDS)) r_err <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_take) begin
                        r_shift    <= {r_shift[55:0], bus.rx_data};
                        r_byte_cnt <= r_byte_cnt + 3'd1;
                    end
                end
                S_WRITE: r_word_idx <= r_word_idx + 32'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_image_loader.sv
// Drives two loaders (base 0 and base 0x3FFF) with one shared byte stream and checks them every cycle
// against a byte-count model of the image format.
module tb_mem_image_loader;

    localparam logic [31:0] BASE0 = 32'h0;
    localparam logic [31:0] BASE1 = 32'h3FFF;
    localparam logic [31:0] MAXW  = 32'h20000;

    logic       clk;
    logic       rstn;
    logic       tb_start;
    logic [7:0] tb_rx_data;
    logic       tb_rx_valid;

    int n_cmp = 0;
    int n_bad = 0;

    mem_image_loader_if u_if0 ();
    mem_image_loader_if u_if1 ();

    assign u_if0.start    = tb_start;
    assign u_if0.rx_data  = tb_rx_data;
    assign u_if0.rx_valid = tb_rx_valid;
    assign u_if1.start    = tb_start;
    assign u_if1.rx_data  = tb_rx_data;
    assign u_if1.rx_valid = tb_rx_valid;

    mem_image_loader #(.BASE_ADDR(BASE0), .MAX_WORDS(MAXW)) u_dut0 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (u_if0.master)
    );

    mem_image_loader #(.BASE_ADDR(BASE1), .MAX_WORDS(MAXW)) u_dut1 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (u_if1.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the load is described only by how many bytes have been accepted so far.
    logic        m_active;
    int          m_n;
    logic [31:0] m_cnt;
    logic [63:0] m_sh;
    logic        m_err;
    logic        m_wr;
    logic        m_done;
    logic [31:0] m_widx;

    logic [31:0] la0[$];
    logic [63:0] ld0[$];
    logic [31:0] la1[$];

    task automatic model_reset();
        m_active = 1'b0; m_n = 0; m_cnt = '0; m_sh = '0;
        m_err = 1'b0; m_wr = 1'b0; m_done = 1'b0; m_widx = '0;
    endtask

    task automatic check_dut(input int d, input logic [31:0] base, input logic il, input logic rr,
                             input logic [7:0] wea, input logic dn, input logic er,
                             input logic [31:0] addr, input logic [63:0] dina, input logic [31:0] wc);
        string p;
        p = (d == 0) ? "dut0" : "dut1";
        if (!rstn) begin
            chk({p, ".rst_interlock"}, il, 0);
            chk({p, ".rst_rx_ready"}, rr, 0);
            chk({p, ".rst_wea"}, wea, 0);
            chk({p, ".rst_done"}, dn, 0);
            chk({p, ".rst_err"}, er, 0);
            chk({p, ".rst_addr"}, addr, base);
            chk({p, ".rst_dina"}, dina, 0);
            chk({p, ".rst_word_count"}, wc, 0);
        end else begin
            chk({p, ".interlock"}, il, m_active);
            chk({p, ".rx_ready"}, rr, m_active && !m_wr && !m_done);
            chk({p, ".wea"}, wea, m_wr ? 8'hFF : 8'h00);
            chk({p, ".done"}, dn, m_done);
            chk({p, ".err"}, er, m_err);
            if (m_wr) begin
                chk({p, ".addr"}, addr, base + m_widx);
                chk({p, ".dina"}, dina, m_sh);
            end
            if (m_done) chk({p, ".word_count"}, wc, m_cnt);
            if (wea == 8'hFF) begin
                if (d == 0) begin la0.push_back(addr); ld0.push_back(dina); end
                else        la1.push_back(addr);
            end
        end
    endtask

    task automatic model_step();
        logic nx_wr, nx_done, nx_active;
        nx_wr = 1'b0; nx_done = 1'b0; nx_active = m_active;
        if (!m_active) begin
            if (tb_start) begin
                nx_active = 1'b1; m_n = 0; m_err = 1'b0; m_cnt = '0;
            end
        end else if (m_done) begin
            nx_active = 1'b0;
        end else if (m_wr) begin
            if (m_widx + 32'd1 == m_cnt) nx_done = 1'b1;
        end else if (tb_rx_valid) begin
            m_n++;
            if (m_n <= 4) m_cnt = {m_cnt[23:0], tb_rx_data};
            else          m_sh  = {m_sh[55:0], tb_rx_data};
            if (m_n == 4) begin
                if (m_cnt == 0) nx_done = 1'b1;
                else if (m_cnt > MAXW) begin nx_done = 1'b1; m_err = 1'b1; end
            end else if (m_n > 4 && ((m_n - 4) % 8) == 0) begin
                nx_wr  = 1'b1;
                m_widx = 32'((m_n - 4) / 8 - 1);
            end
        end
        m_wr = nx_wr; m_done = nx_done; m_active = nx_active;
    endtask

    always @(negedge clk) begin
        check_dut(0, BASE0, u_if0.interlock, u_if0.rx_ready, u_if0.mem_wea, u_if0.done, u_if0.err,
                  u_if0.mem_addr, u_if0.mem_dina, u_if0.word_count);
        check_dut(1, BASE1, u_if1.interlock, u_if1.rx_ready, u_if1.mem_wea, u_if1.done, u_if1.err,
                  u_if1.mem_addr, u_if1.mem_dina, u_if1.word_count);
        if (!rstn) model_reset();
        else       model_step();
    end

    // Stimulus
    int          gap_mode = 0;
    bit          tog = 1'b1;
    logic [63:0] wdat[8];

    task automatic send_byte(input logic [7:0] b);
        bit sent = 1'b0;
        bit v;
        bit acc;
        int guard = 0;
        while (!sent) begin
            case (gap_mode)
                0:       v = 1'b1;
                1:       begin v = tog; tog = ~tog; end
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            tb_rx_valid = v;
            tb_rx_data  = v ? b : 8'($urandom);
            @(negedge clk);
            acc = v && u_if0.rx_ready;
            @(posedge clk); #1;
            if (acc) sent = 1'b1;
            guard++;
            if (!sent && guard > 50) begin
                n_cmp++; n_bad++;
                $display("FAIL byte_accept_timeout: byte %h never accepted", b);
                sent = 1'b1;
            end
        end
        tb_rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        tb_start = 1'b1;
        @(posedge clk); #1;
        tb_start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (u_if0.done) seen = 1'b1;
        end
        @(posedge clk); #1;
        if (!seen) begin
            n_cmp++; n_bad++;
            $display("FAIL done_timeout: done never pulsed, expected within 200 cycles");
        end
    endtask

    task automatic send_hdr(input logic [31:0] cnt);
        for (int k = 3; k >= 0; k--) send_byte(cnt[k*8 +: 8]);
    endtask

    task automatic run_load(input logic [31:0] cnt, input int nwords, input bit mid_start);
        la0.delete(); ld0.delete(); la1.delete();
        pulse_start();
        send_hdr(cnt);
        for (int w = 0; w < nwords; w++) begin
            for (int k = 7; k >= 0; k--) begin
                send_byte(wdat[w][k*8 +: 8]);
                if (mid_start && w == 0 && k == 5) pulse_start();
            end
        end
        wait_done();
    endtask

    initial begin
        rstn = 1'b0; tb_start = 1'b0; tb_rx_data = 8'h0; tb_rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_addr1", u_if1.mem_addr, 32'h3FFF);
        chk("reset_interlock", u_if0.interlock, 0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Bytes offered while idle must not be consumed
        tb_rx_valid = 1'b1; tb_rx_data = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        tb_rx_valid = 1'b0;

        // Zero-length image
        run_load(32'h0, 0, 1'b0);
        chk("zero_writes", la0.size(), 0);
        chk("zero_word_count", u_if0.word_count, 0);
        chk("zero_err", u_if0.err, 0);
        chk("zero_interlock_low", u_if0.interlock, 0);

        // Single word
        wdat[0] = 64'h0102030405060708;
        run_load(32'h1, 1, 1'b0);
        chk("one_writes", la0.size(), 1);
        chk("one_addr", la0[0], 32'h0);
        chk("one_data", ld0[0], 64'h0102030405060708);

        // Three words, valid toggling, stray start mid-load
        gap_mode = 1;
        for (int w = 0; w < 3; w++) wdat[w] = {$urandom, $urandom};
        run_load(32'h3, 3, 1'b1);
        chk("three_writes", la0.size(), 3);
        chk("three_addr2", la0[2], 32'h2);
        chk("three_data2", ld0[2], wdat[2]);

        // Bank crossing on the 0x3FFF instance
        gap_mode = 0;
        for (int w = 0; w < 2; w++) wdat[w] = {$urandom, $urandom};
        run_load(32'h2, 2, 1'b0);
        chk("bank_writes", la1.size(), 2);
        chk("bank_addr0", la1[0], 32'h3FFF);
        chk("bank_addr1", la1[1], 32'h4000);

        // Oversize header, then a fresh start clears err
        run_load(32'h00020001, 0, 1'b0);
        chk("over_err", u_if0.err, 1);
        chk("over_writes", la0.size(), 0);
        chk("over_word_count", u_if0.word_count, 32'h00020001);
        pulse_start();
        chk("over_err_cleared", u_if0.err, 0);
        send_hdr(32'h0);
        wait_done();

        // Reset part-way through word 0
        pulse_start();
        send_hdr(32'h1);
        for (int k = 0; k < 3; k++) send_byte(8'hEE);
        rstn = 1'b0;
        #1;
        chk("mid_rst_wea", u_if0.mem_wea, 0);
        chk("mid_rst_interlock", u_if0.interlock, 0);
        chk("mid_rst_rx_ready", u_if0.rx_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        wdat[0] = 64'hCAFEF00D12345678;
        run_load(32'h1, 1, 1'b0);
        chk("post_rst_writes", la0.size(), 1);
        chk("post_rst_addr", la0[0], 32'h0);
        chk("post_rst_data", ld0[0], 64'hCAFEF00D12345678);

        // Random images with random gaps
        gap_mode = 2;
        for (int r = 0; r < 5; r++) begin
            int cnt;
            cnt = $urandom_range(1, 5);
            for (int w = 0; w < cnt; w++) wdat[w] = {$urandom, $urandom};
            run_load(32'(cnt), cnt, r[0]);
            chk("rand_writes", la0.size(), cnt);
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_image_loader.md
Name: mem_image_loader

Overview:
- Loads a memory image into the banked data RAM through the same addr/dina/wea write interface the memory stage drives.
- Consumes a byte stream from the UART receiver, assembles bytes into 64-bit words and issues one full-word write per word.
- Holds the pipeline interlock while a load is in progress.
- Sits beside the memory stage. Its write port is muxed onto the RAM write inputs while interlock is high.

Parameters:
- BASE_ADDR, 32'h0, word address of the first word written.
- MAX_WORDS, 32'h20000, largest accepted word count; this is 8 banks x 2^14 words.

Ports:
- clk  in  1  system clock; all state is updated on the rising edge.
- rstn  in  1  reset, asynchronous and active-low.
- start  in  1  single-cycle pulse that begins a load; ignored unless the block is IDLE.
- rx_data  in  8  stream byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader can accept a byte.
- mem_addr  out  32  word address; bank = [16:14], index = [13:0].
- mem_dina  out  64  write data.
- mem_wea  out  8  byte write enables; 8'hFF or 8'h00 only.
- interlock  out  1  stalls the pipeline; high whenever the state is not IDLE.
- done  out  1  one-cycle pulse when the load ends.
- err  out  1  count in the last header exceeded MAX_WORDS; sticky until the next start.
- word_count  out  32  count taken from the last header.

Behaviour:
- Reset (async, rstn=0): state IDLE; rx_ready=0, mem_wea=0, mem_addr=BASE_ADDR, mem_dina=0, interlock=0, done=0, err=0, word_count=0; byte and word counters 0.
- Byte handshake: a byte transfers on a rising edge where rx_valid && rx_ready. rx_valid may drop at any time; no data is lost or duplicated across gaps.
- rx_ready = 1 only in HDR and DATA.
- Byte order is big-endian throughout.
  - Header: the first byte goes to bits [31:24].
  - Data: the first byte goes to bits [63:56].
- IDLE:
  - start=1 -> HDR; clear err and the counters; interlock rises the cycle after start.
- HDR: accept 4 bytes into word_count.
  - On the 4th byte, count==0 -> DONE.
  - count>MAX_WORDS -> DONE with err=1; no writes are issued.
  - Otherwise -> DATA.
- DATA: accept 8 bytes into a shift register. On the 8th byte -> WRITE.
- WRITE: exactly one cycle.
  - mem_wea=8'hFF, mem_dina=assembled word, mem_addr=BASE_ADDR+word_idx.
  - word_idx increments.
  - If word_idx+1==word_count -> DONE, else -> DATA.
  - mem_addr/mem_dina stay stable for the whole cycle, covering the memory's negedge sampling.
- DONE: done=1 for one cycle, interlock still 1; then -> IDLE.
- Output defaults: mem_wea=0 in every state except WRITE.
- Address arithmetic is 32-bit with no wrap check beyond MAX_WORDS.
  - Crossing a 2^14 boundary moves to the next bank naturally, e.g. 0x3FFF -> 0x4000.
- Boundary cases:
  - start during a load: ignored.
  - rx_valid in IDLE, WRITE or DONE: not consumed, since rx_ready=0.
  - Reset mid-load: mem_wea drops immediately (async); no partial word is ever written; a later start works normally.
- Latency: the write cycle is the cycle after the 8th byte of a word is accepted. done follows the last write by 1 cycle.

Test Plan:
- Zero-length load: start, bytes 00 00 00 00 -> no mem_wea pulse; done one cycle after the 4th byte; word_count=0; err=0; interlock returns to 0.
- Single word: header 00 00 00 01, then 01 02 ... 08 -> one cycle with mem_wea=FF, addr=0, dina=64'h0102030405060708; then done.
- Three words with rx_valid toggling every other cycle -> writes to addr 0, 1, 2 with correct data; exactly 3 wea pulses; rx_ready=0 during each WRITE.
- Bank crossing: BASE_ADDR=32'h3FFF, count 2 -> writes at 32'h3FFF then 32'h4000 (bank 0 then bank 1).
- Oversize header: 00 02 00 01 -> err=1, done, no writes; the next start clears err.
- Reset after 3 data bytes of word 0 -> wea, interlock, rx_ready drop immediately; a fresh single-word load then writes addr 0 correctly.
